// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Byte/half/3-byte/word load-store unit over internal RAM and an
//            external ROM, with unaligned two-word accesses and fault signalling.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int                        ROM_ADDR_WIDTH = 8,
   parameter int                        RAM_ADDR_WIDTH = 8,
   parameter int                        REGION_RANGE   = 24,
   parameter logic [31-REGION_RANGE:0]  ROM_SELECT     = 8'h00,
   parameter logic [31-REGION_RANGE:0]  RAM_SELECT     = 8'h01
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      read_enable,
   input  logic                      write_enable,
   input  logic                      mem_signed,
   input  logic [1:0]                mem_width,
   input  logic [31:0]               address,
   input  logic [31:0]               data_in,
   output logic [31:0]               data_out,
   output logic                      mem_ready,
   output logic                      mem_fault,
   output logic                      rom_read_enable,
   output logic [ROM_ADDR_WIDTH-1:0] rom_address,
   input  logic [31:0]               rom_data_out
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_RD_LO = 3'd1;
   localparam logic [2:0] c_RD_HI = 3'd2;
   localparam logic [2:0] c_WR_LO = 3'd3;
   localparam logic [2:0] c_WR_HI = 3'd4;
   localparam logic [2:0] c_FAULT = 3'd5;
   localparam int         c_RAM_DEPTH = 2 ** RAM_ADDR_WIDTH;

   logic [2:0]                r_state;
   logic                      r_ready;
   logic                      r_fault;
   logic [31:0]               r_data_out;
   logic [31:0]               r_wdata;
   logic [31:0]               r_lo_word;
   logic [1:0]                r_off;
   logic [1:0]                r_width;
   logic                      r_signed;
   logic                      r_is_rom;
   logic                      r_unaligned;
   logic [RAM_ADDR_WIDTH-1:0] r_ram_w;
   logic [ROM_ADDR_WIDTH-1:0] r_rom_w;
   logic [31:0]               r_mem [0:c_RAM_DEPTH-1];
   logic [31:0]               r_ram_q;

   logic [31-REGION_RANGE:0]  w_sel;
   logic                      w_hit_ram;
   logic                      w_hit_rom;
   logic                      w_accept;
   logic                      w_in_unal;
   logic                      w_req_fault;
   logic                      w_hi_phase;
   logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
   logic                      w_ram_we;
   logic [3:0]                w_ram_be;
   logic [31:0]               w_ram_wdata;
   logic [7:0]                w_be_base;
   logic [7:0]                w_be8;
   logic [63:0]               w_wdata64;
   logic [31:0]               w_rd_word;
   logic [63:0]               w_cat;
   logic [31:0]               w_shifted;
   logic [31:0]               w_rd_result;
   logic                      w_unused_addr;

   assign w_sel       = address[31:REGION_RANGE];
   assign w_hit_ram   = (w_sel == RAM_SELECT);
   assign w_hit_rom   = (w_sel == ROM_SELECT);
   assign w_accept    = (r_state == c_IDLE) && r_ready && (read_enable || write_enable);
   assign w_in_unal   = (({1'b0, address[1:0]} + {1'b0, mem_width}) >= 3'd4);
   // RAM decode wins if both selects coincide; ROM is read-only
   assign w_req_fault = !w_hit_ram && (!w_hit_rom || write_enable);
   assign w_unused_addr = ^address;

   assign w_hi_phase = (r_state == c_RD_HI) || (r_state == c_WR_HI);
   assign w_ram_addr = w_hi_phase ? (r_ram_w + RAM_ADDR_WIDTH'(1)) : r_ram_w;

   assign rom_read_enable = r_is_rom && ((r_state == c_RD_LO) || (r_state == c_RD_HI));
   assign rom_address     = (r_state == c_RD_HI) ? (r_rom_w + ROM_ADDR_WIDTH'(1)) : r_rom_w;

   // Byte lanes and data for the {W+1, W} pair; each write phase takes its half
   always_comb begin
      case (r_width)
         2'd0:    w_be_base = 8'b0000_0001;
         2'd1:    w_be_base = 8'b0000_0011;
         2'd2:    w_be_base = 8'b0000_0111;
         default: w_be_base = 8'b0000_1111;
      endcase
   end
   assign w_be8       = w_be_base << r_off;
   assign w_wdata64   = {32'h0, r_wdata} << {r_off, 3'b000};
   assign w_ram_we    = (r_state == c_WR_LO) || (r_state == c_WR_HI);
   assign w_ram_be    = (r_state == c_WR_HI) ? w_be8[7:4] : w_be8[3:0];
   assign w_ram_wdata = (r_state == c_WR_HI) ? w_wdata64[63:32] : w_wdata64[31:0];

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_ram_be[b]) begin
               r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
            end
         end
      end
      r_ram_q <= r_mem[w_ram_addr];
   end

   assign w_rd_word = r_is_rom ? rom_data_out : r_ram_q;
   assign w_cat     = r_unaligned ? {w_rd_word, r_lo_word} : {32'h0, w_rd_word};
   assign w_shifted = 32'(w_cat >> {r_off, 3'b000});

   always_comb begin
      case (r_width)
         2'd0:    w_rd_result = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
         2'd1:    w_rd_result = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
         2'd2:    w_rd_result = {{8{r_signed & w_shifted[23]}},  w_shifted[23:0]};
         default: w_rd_result = w_shifted;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_ready     <= 1'b1;
         r_fault     <= 1'b0;
         r_data_out  <= 32'h0;
         r_wdata     <= 32'h0;
         r_lo_word   <= 32'h0;
         r_off       <= 2'd0;
         r_width     <= 2'd0;
         r_signed    <= 1'b0;
         r_is_rom    <= 1'b0;
         r_unaligned <= 1'b0;
         r_ram_w     <= '0;
         r_rom_w     <= '0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_ready     <= 1'b0;
                  r_wdata     <= data_in;
                  r_off       <= address[1:0];
                  r_width     <= mem_width;
                  r_signed    <= mem_signed;
                  r_is_rom    <= !w_hit_ram && w_hit_rom;
                  r_unaligned <= w_in_unal;
                  r_ram_w     <= address[RAM_ADDR_WIDTH+1:2];
                  r_rom_w     <= address[ROM_ADDR_WIDTH+1:2];
                  if (w_req_fault)       r_state <= c_FAULT;
                  else if (write_enable) r_state <= c_WR_LO;
                  else                   r_state <= c_RD_LO;
               end else if (!r_ready) begin
                  // Final read cycle: memory data for the last word is now valid
                  r_data_out <= w_rd_result;
                  r_ready    <= 1'b1;
               end
            end
            c_RD_LO: r_state <= r_unaligned ? c_RD_HI : c_IDLE;
            c_RD_HI: begin
               r_lo_word <= w_rd_word;
               r_state   <= c_IDLE;
            end
            c_WR_LO: begin
               r_state <= r_unaligned ? c_WR_HI : c_IDLE;
               r_ready <= !r_unaligned;
            end
            c_WR_HI: begin
               r_state <= c_IDLE;
               r_ready <= 1'b1;
            end
            c_FAULT: begin
               r_state <= c_IDLE;
               r_ready <= 1'b1;
               r_fault <= 1'b1;
            end
            default: begin
               r_state <= c_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign data_out  = r_data_out;
   assign mem_ready = r_ready;
   assign mem_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed bench for mem_access_unit against a byte-ring memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_enable, write_enable, mem_signed;
   logic [1:0]  mem_width;
   logic [31:0] address, data_in, data_out, rom_data_out;
   logic        mem_ready, mem_fault, rom_read_enable;
   logic [7:0]  rom_address;

   int   n_cmp = 0;
   int   n_err = 0;
   int   rom_cnt = 0;
   bit   exp_ready = 1'b1;
   bit   exp_fault = 1'b0;
   logic [31:0] exp_data = 32'h0;
   logic [7:0]  mram [0:1023];
   int   m;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .read_enable(read_enable), .write_enable(write_enable),
      .mem_signed(mem_signed), .mem_width(mem_width), .address(address), .data_in(data_in),
      .data_out(data_out), .mem_ready(mem_ready), .mem_fault(mem_fault),
      .rom_read_enable(rom_read_enable), .rom_address(rom_address), .rom_data_out(rom_data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [7:0] i);
      return {i ^ 8'hC3, i ^ 8'h5A, i + 8'h03, i + 8'h80};
   endfunction

   function automatic logic [7:0] rom_byte(input int idx);
      logic [31:0] wd;
      wd = rom_word(8'(idx / 4));
      return wd[8*(idx % 4) +: 8];
   endfunction

   // External ROM: data registered on the strobe edge
   always @(posedge clk) begin
      if (rom_read_enable) begin
         rom_cnt++;
         rom_data_out <= rom_word(rom_address);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Each region is a 1024-byte ring: byte k of an access lives at (addr+k) mod 1024
   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] w,
                                               input bit sg, input bit rom);
      logic [31:0] r;
      int ba;
      r  = 32'h0;
      ba = int'(a[9:0]);
      for (int k = 0; k <= int'(w); k++)
         r[8*k +: 8] = rom ? rom_byte((ba + k) % 1024) : mram[(ba + k) % 1024];
      if (sg && w != 2'd3 && r[8*int'(w) + 7])
         for (int k = int'(w) + 1; k < 4; k++) r[8*k +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      for (int k = 0; k <= int'(w); k++) mram[(int'(a[9:0]) + k) % 1024] = d[8*k +: 8];
   endtask

   always @(negedge clk) begin
      check("mem_ready", 32'(mem_ready), 32'(exp_ready));
      check("mem_fault", 32'(mem_fault), 32'(exp_fault));
      check("data_out", data_out, exp_data);
      if (reset) check("rom_strobe_in_reset", 32'(rom_read_enable), 32'd0);
   end

   task automatic do_access(input bit we, input bit re, input bit sg, input logic [1:0] w,
                            input logic [31:0] a, input logic [31:0] d, output int meas);
      bit          is_ram, is_rom, fault, unal;
      int          lat, rom_exp, rom_before;
      logic [31:0] rv;
      is_ram  = (a[31:24] == 8'h01);
      is_rom  = (a[31:24] == 8'h00);
      fault   = !(is_ram || is_rom) || (we && is_rom);
      unal    = (int'(a[1:0]) + int'(w)) >= 4;
      lat     = fault ? 1 : we ? (unal ? 2 : 1) : (unal ? 3 : 2);
      rom_exp = (!fault && !we && is_rom) ? (unal ? 2 : 1) : 0;
      rv      = model_read(a, w, sg, is_rom);
      @(negedge clk);
      read_enable = re; write_enable = we; mem_signed = sg; mem_width = w;
      address = a; data_in = d;
      rom_before = rom_cnt;
      @(posedge clk); #1;
      exp_ready = 1'b0; exp_fault = 1'b0;
      // Garbage requests while busy must be ignored
      read_enable = 1'b1; write_enable = 1'b1; mem_signed = 1'($urandom);
      mem_width = 2'($urandom); address = {8'h01, 24'($urandom)}; data_in = $urandom;
      meas = 0;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (mem_ready && meas == 0) meas = k;
         if (k == lat) begin
            read_enable = 1'b0; write_enable = 1'b0;
            exp_ready = 1'b1;
            exp_fault = fault;
            if (!fault && !we) exp_data = rv;
            if (!fault && we) model_write(a, w, d);
         end
      end
      check("rom_strobes", 32'(rom_cnt - rom_before), 32'(rom_exp));
   endtask

   task automatic rd(input bit sg, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] lit, input string nm);
      int ml;
      do_access(1'b0, 1'b1, sg, w, a, 32'h0, ml);
      check(nm, data_out, lit);
   endtask

   task automatic wr(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      int ml;
      do_access(1'b1, 1'b0, 1'b0, w, a, d, ml);
   endtask

   initial begin
      reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0; mem_signed = 1'b0;
      mem_width = 2'd0; address = 32'h0; data_in = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(mem_ready), 32'd1);
      check("reset_data_out", data_out, 32'h0);
      check("reset_rom_strobe", 32'(rom_read_enable), 32'd0);
      reset = 1'b0;

      // Aligned word write then read, with latencies
      do_access(1'b1, 1'b0, 1'b0, 2'd3, 32'h0100_0010, 32'hDEAD_BEEF, m);
      check("lat_wr_aligned", 32'(m), 32'd1);
      do_access(1'b0, 1'b1, 1'b0, 2'd3, 32'h0100_0010, 32'h0, m);
      check("lat_rd_aligned", 32'(m), 32'd2);
      check("rd_word_0x10", data_out, 32'hDEAD_BEEF);

      // Unaligned word
      do_access(1'b1, 1'b0, 1'b0, 2'd3, 32'h0100_0013, 32'h1122_3344, m);
      check("lat_wr_unaligned", 32'(m), 32'd2);
      do_access(1'b0, 1'b1, 1'b0, 2'd3, 32'h0100_0013, 32'h0, m);
      check("lat_rd_unaligned", 32'(m), 32'd3);
      check("rd_word_0x13", data_out, 32'h1122_3344);
      rd(1'b0, 2'd3, 32'h0100_0010, 32'h44AD_BEEF, "rd_lo_word_0x10");
      rd(1'b0, 2'd2, 32'h0100_0014, 32'h0011_2233, "rd_hi_3byte_0x14");

      // Signed / unsigned narrow reads
      wr(2'd0, 32'h0100_0013, 32'h0000_00F0);
      rd(1'b1, 2'd0, 32'h0100_0013, 32'hFFFF_FFF0, "rd_byte_signed");
      rd(1'b0, 2'd0, 32'h0100_0013, 32'h0000_00F0, "rd_byte_unsigned");
      rd(1'b1, 2'd1, 32'h0100_0012, 32'hFFFF_F0AD, "rd_half_signed");
      rd(1'b1, 2'd2, 32'h0100_0011, 32'hFFF0_ADBE, "rd_3byte_signed");
      rd(1'b1, 2'd1, 32'h0100_0013, 32'h0000_33F0, "rd_half_unal_pos");

      // Wrap at the top of RAM
      wr(2'd1, 32'h0100_03FF, 32'h0000_ABCD);
      rd(1'b0, 2'd1, 32'h0100_03FF, 32'h0000_ABCD, "rd_wrap_half");
      rd(1'b0, 2'd0, 32'h0100_03FF, 32'h0000_00CD, "rd_wrap_top_byte");
      rd(1'b0, 2'd0, 32'h0100_0000, 32'h0000_00AB, "rd_wrap_base_byte");

      // Faults leave RAM and data_out alone
      do_access(1'b1, 1'b0, 1'b0, 2'd3, 32'h0000_0004, 32'h1234_5678, m);
      check("lat_fault_rom_write", 32'(m), 32'd1);
      check("fault_keeps_data_out", data_out, 32'h0000_00AB);
      do_access(1'b0, 1'b1, 1'b0, 2'd3, 32'h0200_0000, 32'h0, m);
      check("lat_fault_unmapped", 32'(m), 32'd1);
      check("fault2_keeps_data_out", data_out, 32'h0000_00AB);
      rd(1'b0, 2'd3, 32'h0100_0010, 32'hF0AD_BEEF, "ram_after_faults");

      // Both enables high means write
      do_access(1'b1, 1'b1, 1'b0, 2'd3, 32'h0100_0020, 32'h5566_7788, m);
      check("lat_both_enables", 32'(m), 32'd1);
      rd(1'b0, 2'd3, 32'h0100_0020, 32'h5566_7788, "rd_both_enables");

      // ROM reads
      rd(1'b0, 2'd3, 32'h0000_0008, 32'hC158_0582, "rom_aligned");
      rd(1'b0, 2'd3, 32'h0000_0006, 32'h0582_C25B, "rom_unaligned");
      rd(1'b1, 2'd1, 32'h0000_03FF, 32'hFFFF_803C, "rom_wrap_signed");

      // Reset while the high half of an unaligned write is pending
      wr(2'd3, 32'h0100_0034, 32'h1234_5678);
      wr(2'd3, 32'h0100_0030, 32'h0000_0000);
      @(negedge clk);
      write_enable = 1'b1; read_enable = 1'b0; mem_width = 2'd3;
      address = 32'h0100_0031; data_in = 32'hAABB_CCDD;
      @(posedge clk); #1;
      exp_ready = 1'b0; exp_fault = 1'b0; write_enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      exp_ready = 1'b1; exp_fault = 1'b0; exp_data = 32'h0;
      model_write(32'h0100_0031, 2'd2, 32'h00BB_CCDD);
      #1;
      check("abort_ready", 32'(mem_ready), 32'd1);
      check("abort_data_out", data_out, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rd(1'b0, 2'd3, 32'h0100_0034, 32'h1234_5678, "abort_hi_untouched");
      rd(1'b0, 2'd3, 32'h0100_0030, 32'hBBCC_DD00, "abort_lo_written");
      rd(1'b0, 2'd3, 32'h0100_0010, 32'hF0AD_BEEF, "ram_kept_over_reset");

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  ROM_ADDR_WIDTH, 8, ROM word-index bits
  RAM_ADDR_WIDTH, 8, internal RAM word-index bits (depth 2^RAM_ADDR_WIDTH x 32)
  REGION_RANGE, 24, low address bits owned by one region
  ROM_SELECT, 8'h00, address[31:REGION_RANGE] value selecting ROM
  RAM_SELECT, 8'h01, address[31:REGION_RANGE] value selecting RAM
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high
  read_enable  in  1  read request
  write_enable  in  1  write request
  mem_signed  in  1  sign-extend read result
  mem_width  in  2  access size in bytes minus one (0=byte, 1=half, 2=3 bytes, 3=word)
  address  in  32  byte address
  data_in  in  32  write data, LSB-aligned
  data_out  out  32  read result
  mem_ready  out  1  idle/accepting; rises on completion
  mem_fault  out  1  one-cycle pulse: access rejected
  rom_read_enable  out  1  external ROM read strobe
  rom_address  out  ROM_ADDR_WIDTH  external ROM word index
  rom_data_out  in  32  external ROM data, valid one edge after strobe
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 Requests SHALL be accepted only on a rising edge where mem_ready=1 and read_enable or write_enable=1; address, data_in, mem_width and mem_signed SHALL be latched there; inputs SHALL be ignored while mem_ready=0.
REQ-005 mem_ready SHALL drop on the edge after acceptance and stay low until completion.
REQ-006 If read_enable and write_enable are both high, the request SHALL be a write.
REQ-007 Access SHALL be aligned when address[1:0]+mem_width<4; otherwise unaligned, spanning word W and word W+1.
REQ-008 W+1 SHALL wrap modulo region depth (RAM: 2^RAM_ADDR_WIDTH; ROM: 2^ROM_ADDR_WIDTH) and SHALL stay in the same region.
REQ-009 FSM states SHALL be IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FAULT.
  IDLE->WR_LO (write), ->RD_LO (read), ->FAULT (unmapped select, or write to ROM).
  RD_LO->RD_HI if unaligned, else ->IDLE.
  WR_LO->WR_HI if unaligned, else ->IDLE.
  RD_HI, WR_HI and FAULT->IDLE.
REQ-010 Latency, counted in edges from the accepting edge to mem_ready=1, SHALL be: aligned read 2, unaligned read 3, aligned write 1, unaligned write 2, fault 1.
REQ-011 Internal RAM SHALL have registered read (1-cycle) and per-byte write enables; a write SHALL modify only the addressed bytes; no read-modify-write cycle SHALL occur.
REQ-012 For an unaligned write, bytes SHALL be split: low word gets bytes offset..3, high word the remainder, in the same little-endian order as data_in.
REQ-013 Read assembly SHALL be little-endian: byte k of the result comes from byte (offset+k) of the {W+1,W} concatenation; bytes above mem_width SHALL be zero.
REQ-014 If mem_signed=1, the result SHALL be sign-extended from bit 7/15/23 for widths 0/1/2; width 3 SHALL be unchanged.
REQ-015 data_out SHALL update only on read completion and hold its value otherwise; writes and faults SHALL NOT change it.
REQ-016 FAULT SHALL assert mem_fault for exactly one cycle, coincident with mem_ready returning high, and SHALL issue no memory write and no ROM strobe.
REQ-017 rom_read_enable SHALL pulse one cycle per ROM word read; rom_address SHALL hold the word index for that cycle.

Reset
REQ-018 While reset is high: state=IDLE, mem_ready=1, mem_fault=0, data_out=0, rom_read_enable=0.
REQ-019 Reset mid-operation SHALL abort the access; no write strobe SHALL occur after reset asserts; RAM contents SHALL NOT be cleared.

Verification
REQ-020 Aligned word: write 0x01000010 <- 0xDEADBEEF, width 3, then read -> mem_ready returns after 1 then 2 edges; data_out=0xDEADBEEF.
REQ-021 Unaligned word: write 0x01000013 <- 0x11223344, then read -> 3-edge read; word 0x10 byte3=0x44, word 0x14 bytes0..2=0x332211; data_out=0x11223344.
REQ-022 Signed byte: read 0x01000013, width 0: mem_signed=1 with byte 0xF0 -> 0xFFFFFFF0; mem_signed=0 -> 0x000000F0.
REQ-023 Wrap: half write at 0x010003FF (RAM_ADDR_WIDTH=8) <- 0xABCD -> word 0xFF byte3=0xCD, word 0x00 byte0=0xAB.
REQ-024 Faults: write to 0x00000004, or read of 0x02000000 -> mem_fault one cycle after 1 edge; RAM and data_out unchanged.
REQ-025 Reset during WR_HI of an unaligned write -> high word untouched; mem_ready=1 and data_out=0 immediately.
